bad_packet_filter_s2: RTL
=========================

Name: bad_packet_filter_s2

Overview:
- Output-side stage of the bad-packet filter.
- Pops one bad-packet indicator (BPI) per packet from the BPI FIFO, then drains the matching packet from the packet FIFO.
- Good packets are forwarded on AXIS_OUT; bad packets are silently discarded.
- Sits between the packet/BPI FIFO read ports and the downstream consumer; keeps saturating good/bad packet counters for status registers.

Parameters:
- DATA_WBITS, 512, packet data width in bits.
- DATA_WBYTS, DATA_WBITS/8, TKEEP width.
- CNT_WBITS, 32, width of the packet counters.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- fpkt_out_tdata  input  DATA_WBITS  packet FIFO read data
- fpkt_out_tkeep  input  DATA_WBYTS  packet FIFO read keep
- fpkt_out_tlast  input  1  packet FIFO end-of-packet
- fpkt_out_tvalid  input  1  packet FIFO data valid
- fpkt_out_tready  output  1  packet FIFO pop
- fbpi_out_tdata  input  8  BPI FIFO data; bit 0 = 1 means bad packet
- fbpi_out_tvalid  input  1  BPI FIFO valid
- fbpi_out_tready  output  1  BPI FIFO pop
- AXIS_OUT_TDATA  output  DATA_WBITS  filtered stream data
- AXIS_OUT_TKEEP  output  DATA_WBYTS  filtered stream keep
- AXIS_OUT_TLAST  output  1  filtered stream last
- AXIS_OUT_TVALID  output  1  filtered stream valid
- AXIS_OUT_TREADY  input  1  downstream ready
- clear_counters  input  1  one-cycle pulse; zeroes both counters
- good_packets  output  CNT_WBITS  packets forwarded, saturating
- bad_packets  output  CNT_WBITS  packets discarded, saturating
- dropping  output  1  high while in S_DROP

Behaviour:
- Reset state: fsm = S_WAIT, good_packets = 0, bad_packets = 0. While reset is high, AXIS_OUT_TVALID, fpkt_out_tready and fbpi_out_tready are all 0.
- The packet FIFO and BPI FIFO share this reset. A reset mid-packet abandons the packet; FIFO reset guarantees realignment.

S_WAIT:
- fbpi_out_tready = 1, fpkt_out_tready = 0, AXIS_OUT_TVALID = 0.
- On BPI handshake: go to S_DROP if fbpi_out_tdata[0] = 1, otherwise go to S_PASS.
- Bits 7:1 of the BPI are ignored.

S_PASS:
- AXIS_OUT_TDATA/TKEEP/TLAST/TVALID are driven combinationally from fpkt_out_*.
- fpkt_out_tready = AXIS_OUT_TREADY; fbpi_out_tready = 0.
- A beat moves only when fpkt_out_tvalid and AXIS_OUT_TREADY are both high.
- On a handshake with tlast = 1: good_packets += 1, next state S_WAIT.

S_DROP:
- fpkt_out_tready = 1, AXIS_OUT_TVALID = 0, dropping = 1.
- On a handshake with tlast = 1: bad_packets += 1, next state S_WAIT.

Latency and throughput:
- Zero-latency pass-through of data beats in S_PASS.
- One bubble cycle per packet for the BPI pop (S_WAIT is always at least 1 cycle).
- A single-beat packet therefore takes 2 cycles.

Boundary conditions:
- BPI arrives before packet data: wait in S_PASS/S_DROP with no beats moving.
- Packet data arrives before BPI: no packet beat is consumed until the BPI is popped.
- Empty FIFOs: remain in S_WAIT, all handshakes idle.
- Counters saturate at all-ones and never wrap.
- clear_counters coincident with an increment: clear wins, counter = 0.
- AXIS_OUT_TREADY held low in S_PASS: outputs stay stable (they track FIFO output), no pop occurs.
- dropping is 0 in S_WAIT and S_PASS.

Test Plan:
- Reset, then one 4-beat packet with BPI = 0x00 and AXIS_OUT_TREADY = 1 → 4 beats out with TLAST on beat 4 and data matching; good_packets = 1, bad_packets = 0.
- Packet A (3 beats, BPI 0x01) then packet B (2 beats, BPI 0x00) → only B's 2 beats appear on AXIS_OUT; A's beats are popped with dropping = 1; bad_packets = 1, good_packets = 1.
- Good 8-beat packet with AXIS_OUT_TREADY toggling 1,0,1,0 → no beat lost or duplicated; fpkt_out_tready mirrors AXIS_OUT_TREADY; 8 beats out in order.
- BPI written 5 cycles before packet data, then the reverse ordering → neither case pops a packet beat before its BPI; outputs are correct in both cases.
- Preload good_packets to 0xFFFFFFFE, pass 3 good packets → counter holds at 0xFFFFFFFF. Pulse clear_counters in the same cycle as a tlast handshake → counter = 0.
- Assert reset midway through beat 2 of a 5-beat good packet, also resetting the FIFOs → state returns to S_WAIT, AXIS_OUT_TVALID = 0 during reset, counters = 0; the next packet passes cleanly.

Source files
------------

// File: rtl/bad_packet_filter_s2.sv
// Output stage of the bad-packet filter: pops one BPI per packet, then either
// forwards the matching packet downstream or drains it silently.
module bad_packet_filter_s2 #(
  parameter int DATA_WBITS = 512,
  parameter int DATA_WBYTS = DATA_WBITS / 8,
  parameter int CNT_WBITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WBITS-1:0] fpkt_out_tdata,
  input  logic [DATA_WBYTS-1:0] fpkt_out_tkeep,
  input  logic                  fpkt_out_tlast,
  input  logic                  fpkt_out_tvalid,
  output logic                  fpkt_out_tready,
  input  logic [7:0]            fbpi_out_tdata,
  input  logic                  fbpi_out_tvalid,
  output logic                  fbpi_out_tready,
  output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
  output logic [DATA_WBYTS-1:0] AXIS_OUT_TKEEP,
  output logic                  AXIS_OUT_TLAST,
  output logic                  AXIS_OUT_TVALID,
  input  logic                  AXIS_OUT_TREADY,
  input  logic                  clear_counters,
  output logic [CNT_WBITS-1:0]  good_packets,
  output logic [CNT_WBITS-1:0]  bad_packets,
  output logic                  dropping
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic bpi_hs;
  logic pkt_end;
  logic bpi_unused;
  logic [1:0] cnt_inc;
  logic [CNT_WBITS-1:0] cnt_reg [2];

  assign bpi_hs  = fbpi_out_tvalid & fbpi_out_tready;
  assign pkt_end = fpkt_out_tvalid & fpkt_out_tready & fpkt_out_tlast;
  // Only bit 0 of the indicator carries meaning.
  assign bpi_unused = ^fbpi_out_tdata[7:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT: begin
        if (bpi_hs) begin
          state_next = fbpi_out_tdata[0] ? S_DROP : S_PASS;
        end
      end
      S_PASS, S_DROP: begin
        if (pkt_end) begin
          state_next = S_WAIT;
        end
      end
      default: state_next = S_WAIT;
    endcase
  end

  // Data lanes follow the FIFO head unconditionally; only valid is gated.
  always_comb begin
    AXIS_OUT_TDATA  = fpkt_out_tdata;
    AXIS_OUT_TKEEP  = fpkt_out_tkeep;
    AXIS_OUT_TLAST  = fpkt_out_tlast;
    AXIS_OUT_TVALID = 1'b0;
    fpkt_out_tready = 1'b0;
    fbpi_out_tready = 1'b0;
    dropping        = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_WAIT: fbpi_out_tready = 1'b1;
        S_PASS: begin
          AXIS_OUT_TVALID = fpkt_out_tvalid;
          fpkt_out_tready = AXIS_OUT_TREADY;
        end
        S_DROP: begin
          fpkt_out_tready = 1'b1;
          dropping        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cnt_inc[0] = pkt_end & (state_reg == S_PASS);
  assign cnt_inc[1] = pkt_end & (state_reg == S_DROP);

  // Index 0 counts forwarded packets, index 1 discarded ones; clear beats increment.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset || clear_counters) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && !(&cnt_reg[gi])) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign good_packets = cnt_reg[0];
  assign bad_packets  = cnt_reg[1];

endmodule
